// File: rtl/deframer_if.sv
// Handshake bundle for the deframer: packed words in, unpacked elements out,
// plus lock/footer status.
interface deframer_if #(
  parameter int UnpackedWidth = 1,
  parameter int PackedWidth   = 8
);
  logic                     valid_i;
  logic                     ready_o;
  logic [PackedWidth-1:0]   data_i;
  logic                     valid_o;
  logic                     ready_i;
  logic [UnpackedWidth-1:0] unpacked_o;
  logic                     last_o;
  logic                     locked_o;
  logic                     pkt_ok_o;
  logic                     frame_err_o;
  logic [7:0]               err_cnt_o;

  modport slave (
    input  valid_i, data_i, ready_i,
    output ready_o, valid_o, unpacked_o, last_o, locked_o, pkt_ok_o, frame_err_o, err_cnt_o
  );

  modport master (
    output valid_i, data_i, ready_i,
    input  ready_o, valid_o, unpacked_o, last_o, locked_o, pkt_ok_o, frame_err_o, err_cnt_o
  );
endinterface

// File: rtl/deframer.sv
// Packet deframer: unpacks W payload words per packet into elements, then
// verifies a two-byte footer and hunts for it again after a mismatch.
module deframer #(
  parameter int         UnpackedWidth  = 1,
  parameter int         PackedNum      = 8,
  parameter int         PackedWidth    = UnpackedWidth * PackedNum,
  parameter int         PacketLenElems = 1024,
  parameter logic [7:0] TailByte0      = 8'hA5,
  parameter logic [7:0] TailByte1      = 8'h5A
) (
  input  logic     clk_i,
  input  logic     rst_i,
  deframer_if.slave bus
);
  localparam int Words     = (PacketLenElems + PackedNum - 1) / PackedNum;
  localparam int LastLanes = PacketLenElems - (Words - 1) * PackedNum;
  localparam int CntW      = (Words > 1) ? $clog2(Words) : 1;
  localparam int RemW      = $clog2(PackedNum + 1);

  typedef enum logic [2:0] {S_PAYLOAD, S_TAIL0, S_TAIL1, S_HUNT0, S_HUNT1} state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        wcnt_q, wcnt_d;
  logic [RemW-1:0]        rem_q, rem_d;
  logic [PackedWidth-1:0] buf_q, buf_d;
  logic                   lastw_q, lastw_d;
  logic                   pkt_ok_q, pkt_ok_d;
  logic                   ferr_q, ferr_d;
  logic [7:0]             errc_q, errc_d;

  logic in_fire, out_fire, hit0, hit1, wlast, err_hit;

  assign bus.valid_o     = (rem_q != '0);
  assign bus.unpacked_o  = buf_q[UnpackedWidth-1:0];
  assign bus.last_o      = bus.valid_o && lastw_q && (rem_q == RemW'(1));
  assign bus.locked_o    = (state_q == S_PAYLOAD) || (state_q == S_TAIL0) || (state_q == S_TAIL1);
  assign bus.pkt_ok_o    = pkt_ok_q;
  assign bus.frame_err_o = ferr_q;
  assign bus.err_cnt_o   = errc_q;

  // Accept the next word on the same edge the final lane leaves, so words stream without a bubble.
  assign bus.ready_o = (state_q == S_PAYLOAD) ?
                       ((rem_q == '0) || ((rem_q == RemW'(1)) && bus.ready_i)) : 1'b1;

  assign in_fire  = bus.valid_i && bus.ready_o;
  assign out_fire = bus.valid_o && bus.ready_i;
  assign hit0     = (bus.data_i == PackedWidth'(TailByte0));
  assign hit1     = (bus.data_i == PackedWidth'(TailByte1));
  assign wlast    = (wcnt_q == CntW'(Words - 1));

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    rem_d    = rem_q;
    buf_d    = buf_q;
    lastw_d  = lastw_q;
    pkt_ok_d = 1'b0;
    ferr_d   = 1'b0;
    errc_d   = errc_q;
    err_hit  = 1'b0;

    if (out_fire) begin
      rem_d = rem_q - RemW'(1);
      buf_d = buf_q >> UnpackedWidth;
    end

    if (in_fire) begin
      unique case (state_q)
        S_PAYLOAD: begin
          buf_d   = bus.data_i;
          lastw_d = wlast;
          rem_d   = wlast ? RemW'(LastLanes) : RemW'(PackedNum);
          if (wlast) begin
            wcnt_d  = '0;
            state_d = S_TAIL0;
          end else begin
            wcnt_d  = wcnt_q + CntW'(1);
          end
        end
        S_TAIL0: begin
          if (hit0) state_d = S_TAIL1;
          else begin
            state_d = S_HUNT0;
            err_hit = 1'b1;
          end
        end
        S_TAIL1: begin
          if (hit1) begin
            state_d  = S_PAYLOAD;
            pkt_ok_d = 1'b1;
            wcnt_d   = '0;
          end else begin
            state_d = S_HUNT0;
            err_hit = 1'b1;
          end
        end
        S_HUNT0: if (hit0) state_d = S_HUNT1;
        S_HUNT1: begin
          if (hit1) begin
            state_d = S_PAYLOAD;
            wcnt_d  = '0;
          end else if (!hit0) begin
            state_d = S_HUNT0;
          end
        end
        default: state_d = S_PAYLOAD;
      endcase
    end

    if (err_hit) begin
      ferr_d = 1'b1;
      if (errc_q != 8'hFF) errc_d = errc_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_PAYLOAD;
      wcnt_q   <= '0;
      rem_q    <= '0;
      buf_q    <= '0;
      lastw_q  <= 1'b0;
      pkt_ok_q <= 1'b0;
      ferr_q   <= 1'b0;
      errc_q   <= 8'd0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      rem_q    <= rem_d;
      buf_q    <= buf_d;
      lastw_q  <= lastw_d;
      pkt_ok_q <= pkt_ok_d;
      ferr_q   <= ferr_d;
      errc_q   <= errc_d;
    end
  end
endmodule

// File: tb/tb_deframer.sv
// Self-checking bench for deframer (2-bit elements, 4 per word, 6 per packet).
module tb_deframer;
  localparam int UW = 2;
  localparam int PN = 4;
  localparam int PL = 6;
  localparam int PW = 8;
  localparam int W  = (PL + PN - 1) / PN;

  typedef struct { logic [UW-1:0] v; logic l; int cyc; } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   pkt_cnt = 0;
  int   ferr_cnt = 0;
  int   viol_cnt = 0;
  int   exp_err = 0;
  rec_t got[$];
  rec_t exp_q[$];

  deframer_if #(.UnpackedWidth(UW), .PackedWidth(PW)) bus ();

  deframer #(
    .UnpackedWidth(UW), .PackedNum(PN), .PackedWidth(PW), .PacketLenElems(PL),
    .TailByte0(8'hA5), .TailByte1(8'h5A)
  ) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Observe on the falling edge; inputs only change 1ns after the rising edge.
  always @(negedge clk) begin
    rec_t r;
    if (!rst) begin
      if (bus.valid_o && bus.ready_i) begin
        r.v = bus.unpacked_o; r.l = bus.last_o; r.cyc = cyc;
        got.push_back(r);
      end
      if (bus.pkt_ok_o) pkt_cnt++;
      if (bus.frame_err_o) ferr_cnt++;
      if (bus.locked_o && !bus.valid_o && !bus.ready_o) viol_cnt++;
    end
  end

  // Reference: lanes of each payload word in order, last word only partially used.
  task automatic push_lanes(input logic [7:0] w, input int n, input int first_idx);
    rec_t e;
    for (int k = 0; k < n; k++) begin
      e.v = w[UW*k +: UW];
      e.l = (first_idx + k == PL - 1);
      e.cyc = 0;
      exp_q.push_back(e);
    end
  endtask

  task automatic push_pkt(input logic [7:0] w0, input logic [7:0] w1);
    push_lanes(w0, (W > 1) ? PN : PL, 0);
    if (W > 1) push_lanes(w1, PL - (W - 1) * PN, PN);
  endtask

  task automatic send_word(input logic [7:0] w, input bit rnd);
    bit fire = 1'b0;
    bus.valid_i = 1'b1;
    bus.data_i  = w;
    for (int n = 0; n < 300; n++) begin
      if (rnd) bus.ready_i = 1'($urandom_range(0, 1));
      @(negedge clk);
      fire = bus.ready_o;
      @(posedge clk); #1;
      if (fire) break;
    end
    bus.valid_i = 1'b0;
    if (!fire) begin
      n_cmp++; n_bad++;
      $display("FAIL send_word timeout: word %02h not accepted, ready_o=%0b want 1", w, bus.ready_o);
    end
  endtask

  task automatic send_pkt(input logic [7:0] w0, input logic [7:0] w1, input bit rnd);
    send_word(w0, rnd);
    if (W > 1) send_word(w1, rnd);
  endtask

  task automatic drain(input bit rnd);
    for (int n = 0; n < 500 && got.size() < exp_q.size(); n++) begin
      bus.ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
    end
    bus.ready_i = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
  endtask

  function automatic logic [7:0] bad_byte();
    logic [7:0] v;
    do v = 8'($urandom_range(0, 255)); while (v == 8'hA5 || v == 8'h5A);
    return v;
  endfunction

  task automatic test_reset();
    bus.valid_i = 1'b0; bus.ready_i = 1'b0; bus.data_i = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (bus.valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", bus.valid_o); end
    n_cmp++; if (bus.last_o !== 1'b0) begin n_bad++; $display("FAIL reset_last got %b want 0", bus.last_o); end
    n_cmp++; if (bus.pkt_ok_o !== 1'b0) begin n_bad++; $display("FAIL reset_pkt_ok got %b want 0", bus.pkt_ok_o); end
    n_cmp++; if (bus.frame_err_o !== 1'b0) begin n_bad++; $display("FAIL reset_frame_err got %b want 0", bus.frame_err_o); end
    n_cmp++; if (bus.locked_o !== 1'b1) begin n_bad++; $display("FAIL reset_locked got %b want 1", bus.locked_o); end
    n_cmp++; if (bus.err_cnt_o !== 8'd0) begin n_bad++; $display("FAIL reset_err_cnt got %0d want 0", bus.err_cnt_o); end
    n_cmp++; if (bus.ready_o !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", bus.ready_o); end
    rst = 1'b0;
    exp_err = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int gb = got.size(), eb = exp_q.size(), pk0 = pkt_cnt;
    bus.ready_i = 1'b1;
    push_pkt(8'hE4, 8'h0B);
    send_pkt(8'hE4, 8'h0B, 1'b0);
    send_word(8'hA5, 1'b0);
    send_word(8'h5A, 1'b0);
    drain(1'b0);
    n_cmp++; if (got.size() - gb != 6) begin n_bad++; $display("FAIL basic_count got %0d want 6", got.size() - gb); end
    for (int i = 0; i < exp_q.size() - eb && gb + i < got.size(); i++) begin
      n_cmp++;
      if (got[gb+i].v !== exp_q[eb+i].v || got[gb+i].l !== exp_q[eb+i].l) begin
        n_bad++; $display("FAIL basic_elem[%0d] got v=%0d l=%b want v=%0d l=%b", i, got[gb+i].v, got[gb+i].l, exp_q[eb+i].v, exp_q[eb+i].l);
      end
    end
    n_cmp++; if (pkt_cnt - pk0 != 1) begin n_bad++; $display("FAIL basic_pkt_ok got %0d want 1", pkt_cnt - pk0); end
    n_cmp++; if (bus.err_cnt_o !== 8'd0) begin n_bad++; $display("FAIL basic_err_cnt got %0d want 0", bus.err_cnt_o); end
  endtask

  task automatic test_back_to_back();
    int gb = got.size(), eb = exp_q.size(), pk0 = pkt_cnt, v0 = viol_cnt;
    logic [7:0] a, b;
    bus.ready_i = 1'b1;
    for (int p = 0; p < 2; p++) begin
      a = 8'($urandom); b = 8'($urandom);
      push_pkt(a, b);
      send_pkt(a, b, 1'b0);
      send_word(8'hA5, 1'b0);
      send_word(8'h5A, 1'b0);
    end
    drain(1'b0);
    n_cmp++; if (got.size() - gb != 12) begin n_bad++; $display("FAIL b2b_count got %0d want 12", got.size() - gb); end
    for (int i = 0; i < exp_q.size() - eb && gb + i < got.size(); i++) begin
      n_cmp++;
      if (got[gb+i].v !== exp_q[eb+i].v || got[gb+i].l !== exp_q[eb+i].l) begin
        n_bad++; $display("FAIL b2b_elem[%0d] got v=%0d l=%b want v=%0d l=%b", i, got[gb+i].v, got[gb+i].l, exp_q[eb+i].v, exp_q[eb+i].l);
      end
    end
    for (int p = 0; p < 2 && gb + 6*p + 5 < got.size(); p++) begin
      n_cmp++;
      if (got[gb+6*p+5].cyc - got[gb+6*p].cyc != 5) begin
        n_bad++; $display("FAIL b2b_nobubble pkt%0d span got %0d cycles want 5", p, got[gb+6*p+5].cyc - got[gb+6*p].cyc);
      end
    end
    n_cmp++; if (pkt_cnt - pk0 != 2) begin n_bad++; $display("FAIL b2b_pkt_ok got %0d want 2", pkt_cnt - pk0); end
    n_cmp++; if (viol_cnt != v0) begin n_bad++; $display("FAIL b2b_empty_not_ready got %0d want 0", viol_cnt - v0); end
  endtask

  task automatic test_footer_err();
    int gb = got.size(), eb = exp_q.size(), pk0 = pkt_cnt, fe0 = ferr_cnt;
    bus.ready_i = 1'b1;
    push_pkt(8'hE4, 8'h0B);
    send_pkt(8'hE4, 8'h0B, 1'b0);
    send_word(8'hA5, 1'b0);
    send_word(8'h77, 1'b0);
    exp_err++;
    n_cmp++; if (bus.locked_o !== 1'b0) begin n_bad++; $display("FAIL ferr_unlocked got %b want 0", bus.locked_o); end
    @(posedge clk); #1;
    n_cmp++; if (ferr_cnt - fe0 != 1) begin n_bad++; $display("FAIL ferr_pulse got %0d want 1", ferr_cnt - fe0); end
    n_cmp++; if (bus.err_cnt_o !== 8'd1) begin n_bad++; $display("FAIL ferr_err_cnt got %0d want 1", bus.err_cnt_o); end
    send_word(8'h12, 1'b0);
    send_word(8'hA5, 1'b0);
    send_word(8'hA5, 1'b0);
    send_word(8'h5A, 1'b0);
    n_cmp++; if (bus.locked_o !== 1'b1) begin n_bad++; $display("FAIL ferr_relock got %b want 1", bus.locked_o); end
    push_pkt(8'hE4, 8'h0B);
    send_pkt(8'hE4, 8'h0B, 1'b0);
    send_word(8'hA5, 1'b0);
    send_word(8'h5A, 1'b0);
    drain(1'b0);
    n_cmp++; if (got.size() - gb != 12) begin n_bad++; $display("FAIL ferr_count got %0d want 12", got.size() - gb); end
    for (int i = 0; i < exp_q.size() - eb && gb + i < got.size(); i++) begin
      n_cmp++;
      if (got[gb+i].v !== exp_q[eb+i].v || got[gb+i].l !== exp_q[eb+i].l) begin
        n_bad++; $display("FAIL ferr_elem[%0d] got v=%0d l=%b want v=%0d l=%b", i, got[gb+i].v, got[gb+i].l, exp_q[eb+i].v, exp_q[eb+i].l);
      end
    end
    n_cmp++; if (pkt_cnt - pk0 != 1) begin n_bad++; $display("FAIL ferr_pkt_ok got %0d want 1", pkt_cnt - pk0); end
    n_cmp++; if (ferr_cnt - fe0 != 1) begin n_bad++; $display("FAIL ferr_total got %0d want 1", ferr_cnt - fe0); end
  endtask

  task automatic test_stall();
    int gb = got.size(), eb = exp_q.size();
    bus.ready_i = 1'b1;
    push_pkt(8'hE4, 8'h0B);
    send_word(8'hE4, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    bus.ready_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.unpacked_o !== 2'd3 || bus.valid_o !== 1'b1 || bus.ready_o !== 1'b0 || bus.last_o !== 1'b0) begin
        n_bad++; $display("FAIL stall_hold c%0d got v=%0d vld=%b rdy=%b last=%b want v=3 vld=1 rdy=0 last=0",
                          c, bus.unpacked_o, bus.valid_o, bus.ready_o, bus.last_o);
      end
    end
    @(posedge clk); #1;
    bus.ready_i = 1'b1;
    send_word(8'h0B, 1'b0);
    send_word(8'hA5, 1'b0);
    send_word(8'h5A, 1'b0);
    drain(1'b0);
    n_cmp++; if (got.size() - gb != 6) begin n_bad++; $display("FAIL stall_count got %0d want 6", got.size() - gb); end
    for (int i = 0; i < exp_q.size() - eb && gb + i < got.size(); i++) begin
      n_cmp++;
      if (got[gb+i].v !== exp_q[eb+i].v || got[gb+i].l !== exp_q[eb+i].l) begin
        n_bad++; $display("FAIL stall_elem[%0d] got v=%0d l=%b want v=%0d l=%b", i, got[gb+i].v, got[gb+i].l, exp_q[eb+i].v, exp_q[eb+i].l);
      end
    end
  endtask

  task automatic test_reset_mid();
    int gb = got.size(), eb = exp_q.size(), pk0 = pkt_cnt;
    logic [7:0] a, b;
    bus.ready_i = 1'b1;
    send_word(8'hE4, 1'b0);
    push_lanes(8'hE4, 3, 0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (bus.valid_o !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid got %b want 0", bus.valid_o); end
    n_cmp++; if (bus.err_cnt_o !== 8'd0) begin n_bad++; $display("FAIL rstmid_err_cnt got %0d want 0", bus.err_cnt_o); end
    #3 rst = 1'b0;
    exp_err = 0;
    @(posedge clk); #1;
    a = 8'($urandom); b = 8'($urandom);
    push_pkt(a, b);
    send_pkt(a, b, 1'b0);
    send_word(8'hA5, 1'b0);
    send_word(8'h5A, 1'b0);
    drain(1'b0);
    n_cmp++; if (got.size() - gb != 9) begin n_bad++; $display("FAIL rstmid_count got %0d want 9", got.size() - gb); end
    for (int i = 0; i < exp_q.size() - eb && gb + i < got.size(); i++) begin
      n_cmp++;
      if (got[gb+i].v !== exp_q[eb+i].v || got[gb+i].l !== exp_q[eb+i].l) begin
        n_bad++; $display("FAIL rstmid_elem[%0d] got v=%0d l=%b want v=%0d l=%b", i, got[gb+i].v, got[gb+i].l, exp_q[eb+i].v, exp_q[eb+i].l);
      end
    end
    n_cmp++; if (pkt_cnt - pk0 != 1) begin n_bad++; $display("FAIL rstmid_pkt_ok got %0d want 1", pkt_cnt - pk0); end
  endtask

  task automatic test_random();
    int gb = got.size(), eb = exp_q.size(), pk0 = pkt_cnt, fe0 = ferr_cnt;
    int exp_pk = 0, exp_fe = 0, kind;
    logic [7:0] a, b;
    for (int p = 0; p < 24; p++) begin
      a = 8'($urandom); b = 8'($urandom);
      kind = $urandom_range(0, 2);
      push_pkt(a, b);
      send_pkt(a, b, 1'b1);
      if (kind == 0) begin
        send_word(8'hA5, 1'b1); send_word(8'h5A, 1'b1); exp_pk++;
      end else begin
        if (kind == 2) send_word(8'hA5, 1'b1);
        send_word(bad_byte(), 1'b1);
        for (int g = $urandom_range(0, 2); g > 0; g--) send_word(bad_byte(), 1'b1);
        send_word(8'hA5, 1'b1); send_word(8'h5A, 1'b1);
        exp_fe++; exp_err++;
      end
    end
    drain(1'b1);
    n_cmp++; if (got.size() - gb != exp_q.size() - eb) begin n_bad++; $display("FAIL rand_count got %0d want %0d", got.size() - gb, exp_q.size() - eb); end
    for (int i = 0; i < exp_q.size() - eb && gb + i < got.size(); i++) begin
      n_cmp++;
      if (got[gb+i].v !== exp_q[eb+i].v || got[gb+i].l !== exp_q[eb+i].l) begin
        n_bad++; $display("FAIL rand_elem[%0d] got v=%0d l=%b want v=%0d l=%b", i, got[gb+i].v, got[gb+i].l, exp_q[eb+i].v, exp_q[eb+i].l);
      end
    end
    n_cmp++; if (pkt_cnt - pk0 != exp_pk) begin n_bad++; $display("FAIL rand_pkt_ok got %0d want %0d", pkt_cnt - pk0, exp_pk); end
    n_cmp++; if (ferr_cnt - fe0 != exp_fe) begin n_bad++; $display("FAIL rand_frame_err got %0d want %0d", ferr_cnt - fe0, exp_fe); end
    n_cmp++; if (bus.err_cnt_o !== 8'(exp_err)) begin n_bad++; $display("FAIL rand_err_cnt got %0d want %0d", bus.err_cnt_o, exp_err); end
  endtask

  task automatic test_saturate();
    int gb = got.size(), eb = exp_q.size(), fe0 = ferr_cnt;
    logic [7:0] a, b;
    bus.ready_i = 1'b1;
    for (int p = 0; p < 256; p++) begin
      a = 8'($urandom); b = 8'($urandom);
      push_pkt(a, b);
      send_pkt(a, b, 1'b0);
      send_word(8'hA5, 1'b0);
      send_word(bad_byte(), 1'b0);
      send_word(8'hA5, 1'b0);
      send_word(8'h5A, 1'b0);
      exp_err = (exp_err < 255) ? exp_err + 1 : 255;
      n_cmp++;
      if (bus.err_cnt_o !== 8'(exp_err)) begin
        n_bad++; $display("FAIL sat_err_cnt iter%0d got %0d want %0d", p, bus.err_cnt_o, exp_err);
      end
    end
    drain(1'b0);
    n_cmp++; if (bus.err_cnt_o !== 8'd255) begin n_bad++; $display("FAIL sat_final got %0d want 255", bus.err_cnt_o); end
    n_cmp++; if (ferr_cnt - fe0 != 256) begin n_bad++; $display("FAIL sat_pulses got %0d want 256", ferr_cnt - fe0); end
    n_cmp++; if (got.size() - gb != exp_q.size() - eb) begin n_bad++; $display("FAIL sat_count got %0d want %0d", got.size() - gb, exp_q.size() - eb); end
  endtask

  initial begin
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b0;
    bus.data_i  = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_footer_err();
    test_stall();
    test_reset_mid();
    test_random();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
